jtopl_rhy_pg: RTL and testbench
===============================

# jtopl_rhy_pg

Sequential rhythm-mode phase generator for the JTOPL operator pipeline. It sits between the phase accumulator and the operator stage. It tracks the slot sequence itself, owns the 23-bit noise LFSR, and captures the hi-hat (HH) and top-cymbal (TC) phases as their slots pass. For the HH, SD (snare drum) and TC slots it substitutes the rhythm phase, and it registers the result one `cen` cycle later. Phase width and slot mapping are parametrised for OPL2/OPL3-style pipelines.

## Interface
- `PW`, 10, phase width; must be ≥10.
- `SLOTS`, 18, slots per frame.
- `HH_SLOT`, 13, hi-hat slot index.
- `SD_SLOT`, 16, snare slot index.
- `TC_SLOT`, 17, top-cymbal slot index.
- `rst` in 1: asynchronous, active-high reset.
- `clk` in 1: single clock. All state is on its rising edge.
- `cen` in 1: clock enable. State advances only when `cen`=1.
- `zero` in 1: marks that `phase_pre` belongs to slot 0.
- `rhy_en` in 1: rhythm mode enable (register 0xBD bit 5).
- `phase_pre` in PW: accumulator phase for the current slot.
- `phase_op` out PW: registered phase for the operator stage.
- `slot_op` out 5: slot index of `phase_op`.
- `noise` out 1: current LFSR output bit.

## Operation
- Top-10 view: h(x)[k] = x[PW-10+k].
- Slot tracking:
  - `cnt` is 5 bits; it increments on `cen` and wraps from SLOTS-1 to 0.
  - Current slot `s` = `zero` ? 0 : `cnt`.
  - On `cen`, `cnt` loads `s`+1, wrapping at SLOTS.
- Captures, on `cen`:
  - At `s`=HH_SLOT: `hh_q` ← h(`phase_pre`).
  - At `s`=TC_SLOT: `tc_q` ← h(`phase_pre`).
  - Captures occur regardless of `rhy_en`.
- `rm_xor` sources:
  - hh = h(`phase_pre`) when `s`=HH_SLOT, else `hh_q`.
  - tc = h(`phase_pre`) when `s`=TC_SLOT, else `tc_q`.
  - `rm_xor` = (hh[2]^hh[7]) | (hh[3]^tc[5]) | (tc[3]^tc[5]).
- Noise LFSR:
  - 23 bits, seed 1 at reset.
  - Advances once per frame, on `cen` at `s`=TC_SLOT, after that slot's output is computed.
  - Update: `lfsr` ← {`lfsr`[0]^`lfsr`[14], `lfsr`[22:1]}.
  - `noise` = `lfsr`[0].
- Rhythm value R, 10 bits:
  - HH: {`rm_xor`, 9'd0} | (`rm_xor`^`noise` ? 10'h0D0 : 10'h034).
  - SD: {hh[8], hh[8]^`noise`, 8'd0}.
  - TC: {`rm_xor`, 9'h080}.
- Output mux, on `cen`:
  - When `rhy_en`=1 and `s` ∈ {HH,SD,TC}: `phase_op` ← {R, (PW-10)'d0}.
  - Otherwise: `phase_op` ← `phase_pre`.
  - In all cases `slot_op` ← `s`.
- Other slots are never modified, including the tom slot (14).

## Timing
- Reset values:
  - `phase_op`=0, `slot_op`=0, `cnt`=0.
  - `hh_q`=0, `tc_q`=0.
  - `lfsr`=1, so `noise`=1.
- Latency: `phase_op`/`slot_op` update on the `cen` edge that samples `phase_pre`, so they are valid one `cen` cycle later.
- When `cen`=0, all registers hold and inputs are ignored.
- `zero` arriving mid-frame resyncs the counter. The slot it marks is 0, so no capture or LFSR step happens for the skipped slots.
- `rhy_en` is sampled per slot. A change mid-frame affects only slots processed after the change.
- Reset mid-frame:
  - All state returns immediately to the reset values.
  - The first slot after reset is treated as slot 0 unless `zero` says otherwise.
- At `s`=HH_SLOT, the live HH phase is used with the `tc_q` captured in the previous frame.
- At `s`=SD_SLOT, the `hh_q` captured in the same frame is used.

## Configuration
- Macro: `JTOPL_RHY_EN`.
- Defined: full behaviour as specified above.
- Undefined:
  - The rhythm mux, captures and `rm_xor` logic are removed.
  - `phase_op` ← `phase_pre` on every `cen`; `rhy_en` is ignored.
  - The LFSR and `noise` remain.
  - `slot_op` tracking remains.

## Test plan
- Pass-through: rhy_en=0, PW=10, slot 5, `phase_pre`=0x155 → `phase_op`=0x155 and `slot_op`=5 after one `cen`; same for slots 13/16/17.
- HH substitution, after reset:
  - Stimulus: rhy_en=1, slot 13, `phase_pre`=0x004, `tc_q`=0, noise=1.
  - Expected: rm_xor=1 → `phase_op`=0x234.
  - With the same inputs and noise=0 → 0x2D0.
- SD/TC in the same frame, HH captured as 0x004:
  - Slot 16 with noise=1 → 0x100.
  - Slot 17 with `phase_pre`=0x020 → 0x280.
- LFSR sequence from reset:
  - noise=1 initially.
  - After the 1st frame, noise=0.
  - It stays 0 through the 22nd advance and returns to 1 after the 23rd.
- PW=12: HH case with `phase_pre`=0x010 → `phase_op`=0x8D0 (R=0x234 shifted left 2).
- Resync/reset:
  - `zero` pulsed at `cnt`=7 → next `slot_op`=0, and no HH capture that frame.
  - `rst` asserted mid-frame → all outputs 0, noise=1 without waiting for a clock edge.

Source files
------------

// File: rtl/jtopl_rhy_pg_if.sv
// ----------------------------------------------------------------------------
// jtopl_rhy_pg_if: operator-pipeline bus between phase accumulator, rhythm PG
// and operator stage.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface jtopl_rhy_pg_if #(
  parameter int PW = 10
);
  logic          cen;
  logic          zero;
  logic          rhy_en;
  logic [PW-1:0] phase_pre;
  logic [PW-1:0] phase_op;
  logic [4:0]    slot_op;
  logic          noise;

  modport master (
    output cen, zero, rhy_en, phase_pre,
    input  phase_op, slot_op, noise
  );

  modport slave (
    input  cen, zero, rhy_en, phase_pre,
    output phase_op, slot_op, noise
  );
endinterface

`default_nettype wire

// File: rtl/jtopl_rhy_pg.sv
// ----------------------------------------------------------------------------
// jtopl_rhy_pg: rhythm-mode phase generator (HH/SD/TC substitution, noise LFSR).
// Rhythm logic is built only when JTOPL_RHY_EN is defined.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtopl_rhy_pg #(
  parameter int PW      = 10,
  parameter int SLOTS   = 18,
  parameter int HH_SLOT = 13,
  parameter int SD_SLOT = 16,
  parameter int TC_SLOT = 17
) (
  input  logic          clk,
  input  logic          rst,
  jtopl_rhy_pg_if.slave bus
);
  localparam logic [4:0] c_last = 5'(SLOTS - 1);
  localparam logic [4:0] c_tc   = 5'(TC_SLOT);

  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    slot_op_q, slot_op_d;
  logic [22:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] phase_op_q, phase_op_d;
  logic [4:0]    w_slot;

  // zero overrides the counter so a mid-frame marker resyncs the sequence
  assign w_slot = bus.zero ? 5'd0 : cnt_q;

  always_comb begin
    cnt_d     = cnt_q;
    slot_op_d = slot_op_q;
    lfsr_d    = lfsr_q;
    if (bus.cen) begin
      cnt_d     = (w_slot == c_last) ? 5'd0 : w_slot + 5'd1;
      slot_op_d = w_slot;
      if (w_slot == c_tc)
        lfsr_d = {lfsr_q[0] ^ lfsr_q[14], lfsr_q[22:1]};
    end
  end

`ifdef JTOPL_RHY_EN
  localparam logic [4:0] c_hh = 5'(HH_SLOT);
  localparam logic [4:0] c_sd = 5'(SD_SLOT);

  logic [9:0] hh_q, hh_d, tc_q, tc_d;
  logic [9:0] w_h, w_hh, w_tc, w_r;
  logic       w_rm_xor, w_rhy_slot, w_unused_bits;

  assign w_h  = bus.phase_pre[PW-1 -: 10];
  assign w_hh = (w_slot == c_hh) ? w_h : hh_q;
  assign w_tc = (w_slot == c_tc) ? w_h : tc_q;
  assign w_rm_xor = (w_hh[2] ^ w_hh[7]) | (w_hh[3] ^ w_tc[5]) | (w_tc[3] ^ w_tc[5]);
  assign w_unused_bits = ^{w_hh[9], w_hh[6:4], w_hh[1:0], w_tc[9:6], w_tc[4], w_tc[2:0]};

  // noise here is the pre-advance LFSR bit, the one visible during the TC slot
  always_comb begin
    w_r        = 10'd0;
    w_rhy_slot = 1'b0;
    if (w_slot == c_hh) begin
      w_r        = {w_rm_xor, 9'd0} | ((w_rm_xor ^ lfsr_q[0]) ? 10'h0D0 : 10'h034);
      w_rhy_slot = 1'b1;
    end else if (w_slot == c_sd) begin
      w_r        = {w_hh[8], w_hh[8] ^ lfsr_q[0], 8'd0};
      w_rhy_slot = 1'b1;
    end else if (w_slot == c_tc) begin
      w_r        = {w_rm_xor, 9'h080};
      w_rhy_slot = 1'b1;
    end
  end

  always_comb begin
    hh_d       = hh_q;
    tc_d       = tc_q;
    phase_op_d = phase_op_q;
    if (bus.cen) begin
      if (w_slot == c_hh) hh_d = w_h;
      if (w_slot == c_tc) tc_d = w_h;
      phase_op_d = (bus.rhy_en && w_rhy_slot) ? (PW'(w_r) << (PW - 10)) : bus.phase_pre;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh_q <= 10'd0;
      tc_q <= 10'd0;
    end else begin
      hh_q <= hh_d;
      tc_q <= tc_d;
    end
  end
`else
  logic w_unused_rhy;
  assign w_unused_rhy = bus.rhy_en;

  always_comb begin
    phase_op_d = phase_op_q;
    if (bus.cen) phase_op_d = bus.phase_pre;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      slot_op_q  <= 5'd0;
      lfsr_q     <= 23'd1;
      phase_op_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      slot_op_q  <= slot_op_d;
      lfsr_q     <= lfsr_d;
      phase_op_q <= phase_op_d;
    end
  end

  assign bus.phase_op = phase_op_q;
  assign bus.slot_op  = slot_op_q;
  assign bus.noise    = lfsr_q[0];
endmodule

`default_nettype wire

// File: tb/tb_jtopl_rhy_pg.sv
// ----------------------------------------------------------------------------
// tb_jtopl_rhy_pg: directed table, corner sequences and random run against a
// slot-level reference model, for PW=10 and PW=12 instances.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jtopl_rhy_pg;
`ifdef JTOPL_RHY_EN
  localparam bit RHY = 1'b1;
`else
  localparam bit RHY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  jtopl_rhy_pg_if #(.PW(10)) bus10();
  jtopl_rhy_pg_if #(.PW(12)) bus12();

  jtopl_rhy_pg #(.PW(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));
  jtopl_rhy_pg #(.PW(12)) dut12 (.clk(clk), .rst(rst), .bus(bus12.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: slot counter, captured phases, LFSR as a bit queue (index 0 = output)
  int m_cnt, m_hh, m_tc, m_ph10, m_ph12, m_slot;
  bit m_q[$];

  typedef struct {
    bit         zero;
    bit         rhy;
    logic [9:0] ph;
    logic [9:0] exp_ph;
    logic [4:0] exp_slot;
    bit         exp_noise;
    bit         sub;
  } vec_t;
  vec_t tbl[36];

  function automatic int bt(int x, int k);
    return (x >> k) & 1;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_hh = 0; m_tc = 0; m_ph10 = 0; m_ph12 = 0; m_slot = 0;
    m_q.delete();
    m_q.push_back(1'b1);
    for (int i = 1; i < 23; i++) m_q.push_back(1'b0);
  endtask

  task automatic model_step(bit c, bit z, bit r, int h, int p12);
    int s, hh, tc, rm, nz, rv;
    bit nb;
    if (!c) return;
    s  = z ? 0 : m_cnt;
    hh = (s == 13) ? h : m_hh;
    tc = (s == 17) ? h : m_tc;
    rm = (bt(hh, 2) ^ bt(hh, 7)) | (bt(hh, 3) ^ bt(tc, 5)) | (bt(tc, 3) ^ bt(tc, 5));
    nz = int'(m_q[0]);
    if (s == 13)      rv = rm * 512 + (((rm ^ nz) != 0) ? 'h0D0 : 'h034);
    else if (s == 16) rv = bt(hh, 8) * 512 + (bt(hh, 8) ^ nz) * 256;
    else              rv = rm * 512 + 'h080;
    if (RHY && r && (s == 13 || s == 16 || s == 17)) begin
      m_ph10 = rv;
      m_ph12 = rv * 4;
    end else begin
      m_ph10 = h;
      m_ph12 = p12;
    end
    if (s == 13) m_hh = h;
    if (s == 17) begin
      m_tc = h;
      nb = m_q[0] ^ m_q[14];
      void'(m_q.pop_front());
      m_q.push_back(nb);
    end
    m_slot = s;
    m_cnt  = (s + 1) % 18;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit c, bit z, bit r, logic [9:0] ph, logic [1:0] lo);
    bus10.cen = c; bus10.zero = z; bus10.rhy_en = r; bus10.phase_pre = ph;
    bus12.cen = c; bus12.zero = z; bus12.rhy_en = r; bus12.phase_pre = {ph, lo};
    @(posedge clk);
    model_step(c, z, r, int'(ph), int'({ph, lo}));
    #1;
  endtask

  task automatic cmp_model(string tag);
    check({tag, "_phase10"}, 32'(bus10.phase_op), 32'(m_ph10));
    check({tag, "_slot10"},  32'(bus10.slot_op),  32'(m_slot));
    check({tag, "_noise10"}, 32'(bus10.noise),    32'(m_q[0]));
    check({tag, "_phase12"}, 32'(bus12.phase_op), 32'(m_ph12));
    check({tag, "_slot12"},  32'(bus12.slot_op),  32'(m_slot));
    check({tag, "_noise12"}, 32'(bus12.noise),    32'(m_q[0]));
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_phase10"}, 32'(bus10.phase_op), 32'h0);
    check({tag, "_slot10"},  32'(bus10.slot_op),  32'h0);
    check({tag, "_noise10"}, 32'(bus10.noise),    32'h1);
    check({tag, "_phase12"}, 32'(bus12.phase_op), 32'h0);
    check({tag, "_slot12"},  32'(bus12.slot_op),  32'h0);
    check({tag, "_noise12"}, 32'(bus12.noise),    32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [9:0] ph;
    logic [1:0] lo;
    logic [11:0] exp12;
    bit c, z, r;

    bus10.cen = 0; bus10.zero = 0; bus10.rhy_en = 0; bus10.phase_pre = '0;
    bus12.cen = 0; bus12.zero = 0; bus12.rhy_en = 0; bus12.phase_pre = '0;
    rst = 1'b0;
    model_reset();

    // Two frames from reset: pass-through filler plus the rhythm slots
    for (int i = 0; i < 36; i++) begin
      tbl[i].zero      = ((i % 18) == 0);
      tbl[i].rhy       = 1'b0;
      tbl[i].ph        = 10'h155;
      tbl[i].exp_ph    = 10'h155;
      tbl[i].exp_slot  = 5'(i % 18);
      tbl[i].exp_noise = (i < 17);
      tbl[i].sub       = 1'b0;
    end
    tbl[13].rhy = 1'b1; tbl[13].ph = 10'h004; tbl[13].sub = RHY;
    tbl[13].exp_ph = RHY ? 10'h234 : 10'h004;
    tbl[14].rhy = 1'b1;
    tbl[16].rhy = 1'b1; tbl[16].sub = RHY;
    tbl[16].exp_ph = RHY ? 10'h100 : 10'h155;
    tbl[17].rhy = 1'b1; tbl[17].ph = 10'h020; tbl[17].sub = RHY;
    tbl[17].exp_ph = RHY ? 10'h280 : 10'h020;
    tbl[31].rhy = 1'b1; tbl[31].ph = 10'h004; tbl[31].sub = RHY;
    tbl[31].exp_ph = RHY ? 10'h2D0 : 10'h004;

    #2;
    rst = 1'b1;
    #1;
    check_reset_state("por");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 36; i++) begin
      drive(1'b1, tbl[i].zero, tbl[i].rhy, tbl[i].ph, 2'b10);
      exp12 = tbl[i].sub ? {tbl[i].exp_ph, 2'b00} : {tbl[i].ph, 2'b10};
      check($sformatf("tbl%0d_phase10", i), 32'(bus10.phase_op), 32'(tbl[i].exp_ph));
      check($sformatf("tbl%0d_slot10", i),  32'(bus10.slot_op),  32'(tbl[i].exp_slot));
      check($sformatf("tbl%0d_noise10", i), 32'(bus10.noise),    32'(tbl[i].exp_noise));
      check($sformatf("tbl%0d_phase12", i), 32'(bus12.phase_op), 32'(exp12));
    end

    // LFSR period start: output low for advances 1..22, high again at 23
    do_reset();
    for (int f = 1; f <= 23; f++) begin
      for (int s = 0; s < 18; s++) begin
        ph = 10'($urandom);
        drive(1'b1, s == 0, 1'b0, ph, 2'b00);
      end
      check($sformatf("lfsr_adv%0d_noise10", f), 32'(bus10.noise), 32'(f == 23));
      check($sformatf("lfsr_adv%0d_noise12", f), 32'(bus12.noise), 32'(f == 23));
    end

    // Mid-frame zero pulse at cnt=7 restarts at slot 0
    do_reset();
    for (int s = 0; s < 7; s++) begin
      ph = 10'($urandom);
      drive(1'b1, s == 0, 1'b1, ph, 2'b01);
    end
    ph = 10'($urandom);
    drive(1'b1, 1'b1, 1'b1, ph, 2'b01);
    check("resync_slot10", 32'(bus10.slot_op), 32'h0);
    check("resync_noise10", 32'(bus10.noise), 32'h1);
    for (int s = 0; s < 20; s++) begin
      ph = 10'($urandom);
      drive($urandom_range(0, 3) != 0, 1'b0, 1'b1, ph, 2'(s));
      cmp_model("resync");
    end

    // Asynchronous reset mid-frame after the LFSR has moved away from its seed
    do_reset();
    for (int s = 0; s < 22; s++) begin
      ph = 10'($urandom) | 10'h001;
      drive(1'b1, s == 0, 1'b1, ph, 2'b11);
    end
    check("pre_rst_noise10", 32'(bus10.noise), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    rst = 1'b0;
    model_reset();
    ph = 10'h2AA;
    drive(1'b1, 1'b0, 1'b0, ph, 2'b00);
    check("post_rst_slot10", 32'(bus10.slot_op), 32'h0);
    check("post_rst_phase10", 32'(bus10.phase_op), 32'h2AA);

    // Randomised run against the model, including cen gaps and stray zero pulses
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      c  = ($urandom_range(0, 3) != 0);
      z  = (m_cnt == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
      r  = ($urandom_range(0, 7) != 0);
      ph = 10'($urandom);
      lo = 2'($urandom);
      drive(c, z, r, ph, lo);
      cmp_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
